// File: rtl/kvs_count_pkg.sv
// kvs_count_pkg: engine state encoding, default widths and increment helper
package kvs_count_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, INSERT} state_t;
  localparam int KEY_W_D = 128;
  localparam int VAL_W_D = 32;
  localparam int CNT_W_D = 32;
  localparam int ADDR_W_D = 16;
  function automatic logic [CNT_W_D-1:0] calc_inc(input logic weighted, input logic [CNT_W_D-1:0] weight);
    return weighted ? weight : CNT_W_D'(1);
  endfunction
endpackage

// File: rtl/fifo_sync_ft.sv
// fifo_sync_ft: first-word-fall-through synchronous fifo with fill level
module fifo_sync_ft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             prog_full,
  output logic             empty,
  output logic             valid,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign dout = mem[rd_ptr];
  assign full = level == (AW+1)'(DEPTH);
  assign prog_full = level >= (AW+1)'(DEPTH-2);
  assign empty = level == '0;
  assign valid = !empty;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/kvs_count_engine.sv
// kvs_count_engine: two-phase search/insert key counter driving a KVS and an accumulator
module kvs_count_engine
  import kvs_count_pkg::*;
#(
  parameter int KEY_W = KEY_W_D,
  parameter int VAL_W = VAL_W_D,
  parameter int CNT_W = CNT_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DEPTH = 16,
  parameter int MAX_INFLIGHT = 8,
  parameter int INC_MODE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   kick,
  output logic                   busy,
  output logic                   done,
  input  logic [CNT_W+VAL_W+KEY_W-1:0] din,
  input  logic                   we,
  output logic                   full,
  output logic                   kvs_valid,
  output logic                   kvs_search,
  output logic                   kvs_update,
  output logic [KEY_W-1:0]       kvs_key,
  output logic [VAL_W-1:0]       kvs_value,
  input  logic                   kvs_ready,
  input  logic                   kvs_wait,
  input  logic                   kvs_ack,
  input  logic                   kvs_hit,
  input  logic                   kvs_ent_err,
  input  logic [ADDR_W-1:0]      kvs_addr,
  input  logic [VAL_W-1:0]       kvs_rvalue,
  output logic [ADDR_W-1:0]      accum_addr,
  output logic [VAL_W+CNT_W-1:0] accum_din,
  output logic                   accum_we,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            ins_cnt,
  output logic [31:0]            drop_cnt,
  output logic                   in_ovf
);
  localparam int EW = CNT_W + VAL_W + KEY_W;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [IW-1:0] inflight;
  logic [EW-1:0] in_dout, chk_dout, rest_dout, src;
  logic [AW:0] in_level, chk_level, rest_level;
  logic in_full, in_empty, in_valid, chk_full, chk_pf, chk_empty, chk_valid;
  logic rest_full, rest_pf, rest_empty, rest_valid;
  logic searching, inserting, src_rdy, issue, ack_ok, acc_wr, miss_push, pass_start, unused_ok;
  logic [CNT_W-1:0] inc;
  assign searching = state == SEARCH;
  assign inserting = state == INSERT;
  assign src = searching ? in_dout : rest_dout;
  assign src_rdy = searching ? !in_empty && 32'(rest_level) + 32'(inflight) < DEPTH : inserting && !rest_empty;
  assign issue = src_rdy && !kvs_wait && 32'(inflight) < MAX_INFLIGHT;
  assign ack_ok = kvs_ack && inflight != '0;
  assign acc_wr = ack_ok && (searching ? kvs_hit : !kvs_ent_err);
  assign miss_push = ack_ok && searching && !kvs_hit;
  assign pass_start = state == IDLE && state_nx == SEARCH;
  assign inc = CNT_W'(calc_inc(INC_MODE != 0, CNT_W_D'(chk_dout[KEY_W+VAL_W+:CNT_W])));
  assign unused_ok = ^{in_level, in_valid, chk_level, chk_full, chk_pf, chk_empty, chk_valid, rest_full, rest_pf, rest_valid};
  fifo_sync_ft #(.WIDTH(EW), .DEPTH(DEPTH)) u_in (
    .clk(clk), .srst(reset), .wr_en(we), .din(din), .rd_en(issue && searching),
    .dout(in_dout), .full(in_full), .prog_full(full), .empty(in_empty), .valid(in_valid), .level(in_level)
  );
  fifo_sync_ft #(.WIDTH(EW), .DEPTH(DEPTH)) u_chk (
    .clk(clk), .srst(reset), .wr_en(issue), .din(src), .rd_en(ack_ok),
    .dout(chk_dout), .full(chk_full), .prog_full(chk_pf), .empty(chk_empty), .valid(chk_valid), .level(chk_level)
  );
  fifo_sync_ft #(.WIDTH(EW), .DEPTH(DEPTH)) u_rest (
    .clk(clk), .srst(reset), .wr_en(miss_push), .din(chk_dout), .rd_en(issue && inserting),
    .dout(rest_dout), .full(rest_full), .prog_full(rest_pf), .empty(rest_empty), .valid(rest_valid), .level(rest_level)
  );
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_nx;
  end
  always_comb begin
    state_nx = state == IDLE ? (kick && kvs_ready ? SEARCH : IDLE) :
               searching ? (in_empty && inflight == '0 ? INSERT : SEARCH) :
               (rest_empty && inflight == '0 ? IDLE : INSERT);
  end
  always_comb begin
    busy = state != IDLE;
    done = inserting && rest_empty && inflight == '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      kvs_valid <= 1'b0;
      kvs_search <= 1'b0;
      kvs_update <= 1'b0;
      kvs_key <= '0;
      kvs_value <= '0;
      inflight <= '0;
      accum_we <= 1'b0;
      accum_addr <= '0;
      accum_din <= '0;
      hit_cnt <= '0;
      ins_cnt <= '0;
      drop_cnt <= '0;
      in_ovf <= 1'b0;
    end else begin
      kvs_valid <= issue;
      kvs_search <= issue && searching;
      kvs_update <= issue && inserting;
      if (issue) begin
        kvs_key <= src[KEY_W-1:0];
        kvs_value <= src[KEY_W+:VAL_W];
      end
      inflight <= inflight + IW'(issue) - IW'(ack_ok);
      accum_we <= acc_wr;
      if (acc_wr) begin
        accum_addr <= kvs_addr;
        accum_din <= {kvs_rvalue, inc};
      end
      hit_cnt <= pass_start ? '0 : hit_cnt + 32'(acc_wr && searching && ~&hit_cnt);
      ins_cnt <= pass_start ? '0 : ins_cnt + 32'(acc_wr && inserting && ~&ins_cnt);
      drop_cnt <= pass_start ? '0 : drop_cnt + 32'(ack_ok && inserting && kvs_ent_err && ~&drop_cnt);
      in_ovf <= in_ovf || (we && in_full);
    end
  end
endmodule

// File: tb/tb_kvs_count_engine.sv
// tb_kvs_count_engine: directed checks of two engine builds against a behavioural KVS
module tb_kvs_count_engine;
  logic clk, reset, kick, we, kvs_ready, kvs_wait, wait_edge;
  logic [191:0] din;
  logic busy [2], done [2], full [2], kvs_valid [2], kvs_search [2], kvs_update [2], accum_we [2], in_ovf [2];
  logic [127:0] kvs_key [2];
  logic [31:0] kvs_value [2], kvs_rvalue [2], hit_cnt [2], ins_cnt [2], drop_cnt [2];
  logic kvs_ack [2], kvs_hit [2], kvs_ent_err [2];
  logic [15:0] kvs_addr [2], accum_addr [2];
  logic [63:0] accum_din [2];
  for (genvar g = 0; g < 2; g++) begin : u
    kvs_count_engine #(.MAX_INFLIGHT(g == 0 ? 2 : 4), .INC_MODE(g)) dut (
      .clk(clk), .reset(reset), .kick(kick), .busy(busy[g]), .done(done[g]),
      .din(din), .we(we), .full(full[g]),
      .kvs_valid(kvs_valid[g]), .kvs_search(kvs_search[g]), .kvs_update(kvs_update[g]),
      .kvs_key(kvs_key[g]), .kvs_value(kvs_value[g]),
      .kvs_ready(kvs_ready), .kvs_wait(kvs_wait), .kvs_ack(kvs_ack[g]), .kvs_hit(kvs_hit[g]),
      .kvs_ent_err(kvs_ent_err[g]), .kvs_addr(kvs_addr[g]), .kvs_rvalue(kvs_rvalue[g]),
      .accum_addr(accum_addr[g]), .accum_din(accum_din[g]), .accum_we(accum_we[g]),
      .hit_cnt(hit_cnt[g]), .ins_cnt(ins_cnt[g]), .drop_cnt(drop_cnt[g]), .in_ovf(in_ovf[g])
    );
  end
  int n_chk, n_fail, cyc, lat;
  bit present [2][256];
  bit err_key [256];
  logic [15:0] t_addr [2][256];
  logic [31:0] t_val [2][256];
  int next_addr [2], head [2], tail [2], max_out [2], viol [2], done_n [2], log_n [2], b [2], d [2];
  int q_due [2][64];
  bit q_hit [2][64], q_err [2][64];
  logic [15:0] q_addr [2][64];
  logic [31:0] q_val [2][64];
  logic [15:0] log_addr [2][256];
  logic [63:0] log_din [2][256];
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) wait_edge <= kvs_wait;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_inc(input int unit, input logic [31:0] w);
    return unit == 0 ? 32'd1 : w;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [7:0] key, input logic [31:0] val, input logic [31:0] w);
    din = {w, val, 120'd0, key};
    we = 1;
    @(negedge clk);
    we = 0;
  endtask
  task automatic mark();
    for (int i = 0; i < 2; i++) begin
      b[i] = log_n[i];
      d[i] = done_n[i];
    end
  endtask
  task automatic wait_idle(input string tag);
    int t = 0;
    while ((busy[0] || busy[1]) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_finish"}, 64'(t < 500), 1);
    tick(5);
  endtask
  task automatic run_pass(input string tag);
    kick = 1;
    @(negedge clk);
    kick = 0;
    wait_idle(tag);
  endtask
  task automatic check_acc(input string tag, input int unit, input int idx, input logic [15:0] a, input logic [31:0] v, input logic [31:0] inc);
    check($sformatf("%s_u%0d_addr%0d", tag, unit, idx), log_addr[unit][b[unit]+idx], a);
    check($sformatf("%s_u%0d_din%0d", tag, unit, idx), log_din[unit][b[unit]+idx], {v, inc});
  endtask
  task automatic check_stats(input string tag, input int nacc, input int hit, input int ins, input int drop);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_u%0d_nacc", tag, i), log_n[i] - b[i], nacc);
      check($sformatf("%s_u%0d_hit", tag, i), hit_cnt[i], hit);
      check($sformatf("%s_u%0d_ins", tag, i), ins_cnt[i], ins);
      check($sformatf("%s_u%0d_drop", tag, i), drop_cnt[i], drop);
      check($sformatf("%s_u%0d_done", tag, i), done_n[i] - d[i], 1);
    end
  endtask
  initial begin
    int k, s;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 256; j++) begin
        present[i][j] = 0;
        t_addr[i][j] = '0;
        t_val[i][j] = '0;
      end
      present[i][8'hA] = 1; t_addr[i][8'hA] = 16'd5; t_val[i][8'hA] = 32'h100;
      present[i][8'hB] = 1; t_addr[i][8'hB] = 16'd9; t_val[i][8'hB] = 32'h200;
      present[i][8'hE] = 1; t_addr[i][8'hE] = 16'd3; t_val[i][8'hE] = 32'h55;
      next_addr[i] = 20; head[i] = 0; tail[i] = 0; max_out[i] = 0; viol[i] = 0; done_n[i] = 0; log_n[i] = 0;
      kvs_ack[i] = 0; kvs_hit[i] = 0; kvs_ent_err[i] = 0; kvs_addr[i] = '0; kvs_rvalue[i] = '0;
    end
    for (int j = 0; j < 256; j++) err_key[j] = (j == 8'hF);
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (accum_we[i] && log_n[i] < 256) begin
          log_addr[i][log_n[i]] = accum_addr[i];
          log_din[i][log_n[i]] = accum_din[i];
          log_n[i]++;
        end
        if (done[i]) done_n[i]++;
        if (kvs_valid[i] && (wait_edge || kvs_search[i] == kvs_update[i])) viol[i]++;
        kvs_ack[i] = 0; kvs_hit[i] = 0; kvs_ent_err[i] = 0; kvs_addr[i] = '0; kvs_rvalue[i] = '0;
        if (kvs_valid[i]) begin
          k = int'(kvs_key[i][7:0]);
          s = tail[i] % 64;
          q_due[i][s] = cyc + lat - 1;
          q_hit[i][s] = present[i][k];
          q_err[i][s] = 0;
          if (kvs_update[i] && !present[i][k]) begin
            if (err_key[k]) q_err[i][s] = 1;
            else begin
              present[i][k] = 1;
              t_addr[i][k] = 16'(next_addr[i]);
              t_val[i][k] = kvs_value[i];
              next_addr[i]++;
            end
          end
          q_addr[i][s] = t_addr[i][k];
          q_val[i][s] = t_val[i][k];
          tail[i]++;
        end
        if (tail[i] - head[i] > max_out[i]) max_out[i] = tail[i] - head[i];
        if (head[i] != tail[i] && q_due[i][head[i] % 64] <= cyc) begin
          s = head[i] % 64;
          kvs_ack[i] = 1; kvs_hit[i] = q_hit[i][s]; kvs_ent_err[i] = q_err[i][s];
          kvs_addr[i] = q_addr[i][s]; kvs_rvalue[i] = q_val[i][s];
          head[i]++;
        end
      end
    end
  end
  initial begin
    int t;
    reset = 1; kick = 0; we = 0; din = '0; kvs_ready = 1; kvs_wait = 0; lat = 3;
    tick(3);
    reset = 0;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_u%0d_busy", i), busy[i], 0);
      check($sformatf("rst_u%0d_valid", i), kvs_valid[i], 0);
      check($sformatf("rst_u%0d_ovf", i), in_ovf[i], 0);
      check($sformatf("rst_u%0d_hit", i), hit_cnt[i], 0);
    end
    kvs_ready = 0; kick = 1;
    tick(1);
    kick = 0; kvs_ready = 1;
    tick(1);
    check("kick_not_ready_busy", busy[0], 0);
    mark();
    push(8'hA, 32'h1, 3); push(8'hB, 32'h2, 3); push(8'hA, 32'h1, 3);
    run_pass("t1");
    check_stats("t1", 3, 3, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check_acc("t1", i, 0, 16'd5, 32'h100, exp_inc(i, 3));
      check_acc("t1", i, 1, 16'd9, 32'h200, exp_inc(i, 3));
      check_acc("t1", i, 2, 16'd5, 32'h100, exp_inc(i, 3));
    end
    mark();
    push(8'hC, 32'h30, 2); push(8'hC, 32'h30, 2); push(8'hD, 32'h40, 2);
    run_pass("t2");
    check_stats("t2", 3, 0, 3, 0);
    for (int i = 0; i < 2; i++) begin
      check_acc("t2", i, 0, 16'd20, 32'h30, exp_inc(i, 2));
      check_acc("t2", i, 1, 16'd20, 32'h30, exp_inc(i, 2));
      check_acc("t2", i, 2, 16'd21, 32'h40, exp_inc(i, 2));
    end
    mark();
    for (int j = 0; j < 6; j++) push(j % 2 == 0 ? 8'hA : 8'hB, 32'h0, 1);
    kick = 1;
    tick(1);
    kick = 0;
    tick(1);
    kvs_wait = 1;
    tick(20);
    check("t3_busy_during_wait", busy[0], 1);
    kvs_wait = 0;
    wait_idle("t3");
    check_stats("t3", 6, 6, 0, 0);
    check("t3_u0_max_out", max_out[0], 2);
    check("t3_u1_max_out_le4", 64'(max_out[1] <= 4), 1);
    check("t3_u0_viol", viol[0], 0);
    check("t3_u1_viol", viol[1], 0);
    mark();
    push(8'hE, 32'h0, 7); push(8'hA, 32'h0, 0); push(8'hF, 32'h66, 2);
    run_pass("t4");
    check_stats("t4", 2, 2, 0, 1);
    for (int i = 0; i < 2; i++) begin
      check_acc("t4", i, 0, 16'd3, 32'h55, exp_inc(i, 7));
      check_acc("t4", i, 1, 16'd5, 32'h100, exp_inc(i, 0));
    end
    mark();
    for (int j = 0; j < 13; j++) push(j % 2 == 0 ? 8'hA : 8'hB, 32'h0, 1);
    check("t5_full_at13", full[0], 0);
    push(8'hB, 32'h0, 1);
    check("t5_full_at14", full[0], 1);
    push(8'hA, 32'h0, 1); push(8'hB, 32'h0, 1);
    check("t5_ovf_at16", in_ovf[0], 0);
    push(8'hA, 32'h0, 1);
    check("t5_u0_ovf_at17", in_ovf[0], 1);
    check("t5_u1_ovf_at17", in_ovf[1], 1);
    run_pass("t5");
    check_stats("t5", 16, 16, 0, 0);
    check("t5_ovf_sticky", in_ovf[0], 1);
    lat = 10;
    for (int j = 0; j < 6; j++) push(8'hA, 32'h0, 1);
    kick = 1;
    tick(1);
    kick = 0;
    t = 0;
    while (tail[1] - head[1] < 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("t6_three_outstanding", 64'(t < 50), 1);
    reset = 1;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t6_u%0d_busy", i), busy[i], 0);
      check($sformatf("t6_u%0d_valid", i), kvs_valid[i], 0);
      check($sformatf("t6_u%0d_accwe", i), accum_we[i], 0);
      check($sformatf("t6_u%0d_hit", i), hit_cnt[i], 0);
      check($sformatf("t6_u%0d_ovf", i), in_ovf[i], 0);
      check($sformatf("t6_u%0d_full", i), full[i], 0);
    end
    reset = 0;
    mark();
    tick(20);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t6_u%0d_late_acks", i), log_n[i] - b[i], 0);
      check($sformatf("t6_u%0d_idle", i), busy[i], 0);
    end
    lat = 3;
    mark();
    push(8'hA, 32'h0, 4); push(8'hB, 32'h0, 4);
    run_pass("t7");
    check_stats("t7", 2, 2, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check_acc("t7", i, 0, 16'd5, 32'h100, exp_inc(i, 4));
      check_acc("t7", i, 1, 16'd9, 32'h200, exp_inc(i, 4));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/kvs_count_engine.md
KVS_COUNT_ENGINE -- requirements
Module: kvs_count_engine

Interface
REQ-001 Parameter KEY_W, 128, key width.
REQ-002 Parameter VAL_W, 32, per-key value width.
REQ-003 Parameter CNT_W, 32, increment/count width.
REQ-004 Parameter ADDR_W, 16, KVS entry address width.
REQ-005 Parameter DEPTH, 16, depth of each internal FIFO (power of 2, ≥4).
REQ-006 Parameter MAX_INFLIGHT, 8, max outstanding KVS commands (≤DEPTH).
REQ-007 Parameter INC_MODE, 0, 0 = increment 1; 1 = increment from din weight field.
REQ-008 clk  in  1  single clock; one clock; reset is synchronous and active-high.
REQ-009 reset  in  1  synchronous, active-high.
REQ-010 kick  in  1  start pass; busy  out  1  pass in progress; done  out  1  one-cycle pulse at pass end.
REQ-011 din  in  CNT_W+VAL_W+KEY_W  {weight, value, key}; we  in  1  write; full  out  1  input FIFO at DEPTH-2.
REQ-012 kvs_valid, kvs_search, kvs_update  out  1 each; kvs_key  out  KEY_W; kvs_value  out  VAL_W.
REQ-013 kvs_ready, kvs_wait, kvs_ack, kvs_hit, kvs_ent_err  in  1 each; kvs_addr  in  ADDR_W; kvs_rvalue  in  VAL_W.
REQ-014 accum_addr  out  ADDR_W; accum_din  out  VAL_W+CNT_W {value, increment}; accum_we  out  1.
REQ-015 hit_cnt, ins_cnt, drop_cnt  out  32 each  per-pass statistics; in_ovf  out  1  sticky input overflow.

Function
REQ-016 States IDLE, SEARCH, INSERT; IDLE->SEARCH on kick while kvs_ready=1; kick in any other state ignored.
REQ-017 Entering SEARCH clears hit_cnt, ins_cnt, drop_cnt; busy=1 in SEARCH/INSERT, 0 in IDLE.
REQ-018 SEARCH: issue when input FIFO non-empty, kvs_wait=0, inflight<MAX_INFLIGHT, rest FIFO not full: kvs_valid=1, kvs_search=1, kvs_update=0, key/value from FIFO head; entry pushed to check FIFO same cycle.
REQ-019 kvs_valid is a single-cycle pulse per command, registered; no command issued in IDLE.
REQ-020 Each kvs_ack pops check FIFO; hit -> accum_we=1, accum_addr=kvs_addr, accum_din={kvs_rvalue, inc}, hit_cnt+1; miss -> push popped entry to rest FIFO.
REQ-021 inc = 1 (zero-extended) when INC_MODE=0, weight field when INC_MODE=1; weight 0 in mode 1 still counts as hit/insert.
REQ-022 inflight +1 on issue, -1 on ack, unchanged when both same cycle; ack with inflight=0 ignored.
REQ-023 SEARCH->INSERT when input FIFO empty and inflight=0 (same cycle allowed).
REQ-024 INSERT: same issue rules from rest FIFO with kvs_update=1, kvs_search=0; rest entry pushed to check FIFO.
REQ-025 INSERT ack with kvs_ent_err=0 -> accum write as REQ-020, ins_cnt+1; kvs_ent_err=1 -> no accum write, drop_cnt+1.
REQ-026 INSERT->IDLE when rest FIFO empty and inflight=0; done=1 for that cycle.
REQ-027 accum_we is one-cycle per ack; accum latency = 1 cycle after kvs_ack.
REQ-028 we while input FIFO full: word discarded, in_ovf=1 until reset; we accepted in any state.
REQ-029 Statistic counters saturate at 2^32-1.

Reset
REQ-030 reset: state IDLE, all FIFOs flushed, inflight=0, all outputs 0 incl. counters and in_ovf, next cycle.
REQ-031 Reset mid-pass abandons outstanding acks; acks arriving after reset ignored (inflight=0).

Structure
REQ-032 Package kvs_count_pkg: state enum, default width constants, inc computation function.
REQ-033 Sub-module fifo_sync_ft (first-word-fall-through, WIDTH/DEPTH params, srst, full/prog_full/empty/valid), instantiated for input, check, rest.

Verification
REQ-034 INC_MODE=0, keys A,B,A preloaded in KVS model (A@5, B@9), latency 3 -> accum writes (5,1),(9,1),(5,1); hit_cnt=3, done once.
REQ-035 Empty KVS, keys C,C,D -> SEARCH misses 3, INSERT 3 updates, ins_cnt=3, accum writes addr of C twice.
REQ-036 kvs_wait held 20 cycles mid-SEARCH, MAX_INFLIGHT=2 -> never >2 outstanding, no command during wait, no data loss.
REQ-037 INC_MODE=1, key E weight 7 hit @3 -> accum_din low CNT_W=7; ent_err on F insert -> drop_cnt=1, no accum write.
REQ-038 17 writes to DEPTH=16 FIFO without kick -> in_ovf=1, 16 processed after kick.
REQ-039 reset asserted with 3 in flight -> outputs 0 next cycle, late acks produce no accum_we, subsequent kick pass correct.
